// File: rtl/complex_mult_pipe.sv
// complex_mult_pipe: 3-stage pipelined complex multiplier with valid/ready
// handshake, per-sample conjugation, optional round-half-up and a global
// backpressure stall.
//   OUT = IN0 * IN1          (CONJ = 0)
//   OUT = IN0 * conj(IN1)    (CONJ = 1)
// Optional feature macro: CMUL_SAT_EN
//   defined   -> output saturates, OVF is a sticky saturation flag
//   undefined -> output wraps to OUT_W bits, OVF tied low

// Per-component round / scale / reduce. Instantiated once for the real part
// and once for the imaginary part.
module cmul_scale #(
  parameter int P     = 29,
  parameter int OUT_W = 16,
  parameter int SH    = 10,
  parameter int ROUND = 1
) (
  input  logic signed [P-1:0]     sum,
  output logic signed [OUT_W-1:0] res
`ifdef CMUL_SAT_EN
  , output logic                  sat
`endif
);
  // Half an output LSB, only when rounding is on and bits are discarded.
  localparam int RSH = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [P-1:0] RND = (ROUND != 0 && SH > 0) ? (P'(1) << RSH) : '0;

  logic signed [P-1:0] biased;
  assign biased = sum + RND;

`ifdef CMUL_SAT_EN
  localparam logic signed [P-1:0] MAXV = {{(P-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P-1:0] MINV = {{(P-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [P-1:0] shifted;
  assign shifted = biased >>> SH;

  // Clamp the scaled sum into the signed OUT_W range and flag the clamp.
  always_comb begin
    sat = 1'b0;
    res = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      sat = 1'b1;
      res = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      sat = 1'b1;
      res = MINV[OUT_W-1:0];
    end
  end
`else
  // Wrap: keep the low OUT_W bits of the scaled sum.
  assign res = OUT_W'(biased >>> SH);
`endif
endmodule

module complex_mult_pipe #(
  parameter int IN0_W    = 16,
  parameter int IN0_FRAC = 8,
  parameter int IN1_W    = 12,
  parameter int IN1_FRAC = 10,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int ROUND    = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CONJ,
  input  logic [IN0_W-1:0] IN0_Real,
  input  logic [IN0_W-1:0] IN0_Img,
  input  logic [IN1_W-1:0] IN1_Real,
  input  logic [IN1_W-1:0] IN1_Img,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT_Real,
  output logic [OUT_W-1:0] OUT_Img,
  output logic             OVF
);
  localparam int STAGES = 3;
  localparam int PW     = IN0_W + IN1_W;          // full-precision product
  localparam int P      = PW + 1;                 // sum of two products
  localparam int SH     = IN0_FRAC + IN1_FRAC - OUT_FRAC;

  if (OUT_FRAC > IN0_FRAC + IN1_FRAC) begin : g_frac_chk
    $error("complex_mult_pipe: OUT_FRAC must not exceed IN0_FRAC + IN1_FRAC");
  end

  typedef struct packed {
    logic             conj;
    logic [IN0_W-1:0] ar;
    logic [IN0_W-1:0] ai;
    logic [IN1_W-1:0] br;
    logic [IN1_W-1:0] bi;
  } s1_t;

  typedef struct packed {
    logic          conj;
    logic [PW-1:0] rr;   // ar*br
    logic [PW-1:0] ii;   // ai*bi
    logic [PW-1:0] ri;   // ar*bi
    logic [PW-1:0] ir;   // ai*br
  } s2_t;

  // vld_pipe[0] is the accept strobe, [1..3] are the stage valids.
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            stall;
  s1_t             s1;
  s2_t             s2;
  logic [1:0][OUT_W-1:0] out_q;

  assign stall     = vld_pipe[STAGES] & ~OUT_READY;
  assign IN_READY  = ~stall;
  assign vld_pipe  = {vld_q, IN_VALID & ~stall};
  assign OUT_VALID = vld_pipe[STAGES];
  assign OUT_Real  = out_q[0];
  assign OUT_Img   = out_q[1];

  // Valid shift register; the whole pipe freezes on stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      vld_q <= '0;
    else if (!stall) vld_q <= vld_pipe[STAGES-1:0];
  end

  // S1: capture operands and the conjugate flag that rides with them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      s1 <= '0;
    else if (!stall) s1 <= '{conj: CONJ, ar: IN0_Real, ai: IN0_Img,
                             br: IN1_Real, bi: IN1_Img};
  end

  // Sign-extend operands to product width so the multiply is exactly PW bits.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = {{IN1_W{s1.ar[IN0_W-1]}}, s1.ar};
  assign ai_x = {{IN1_W{s1.ai[IN0_W-1]}}, s1.ai};
  assign br_x = {{IN0_W{s1.br[IN1_W-1]}}, s1.br};
  assign bi_x = {{IN0_W{s1.bi[IN1_W-1]}}, s1.bi};

  // S2: four full-precision partial products.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      s2 <= '0;
    else if (!stall) s2 <= '{conj: s1.conj, rr: ar_x * br_x, ii: ai_x * bi_x,
                             ri: ar_x * bi_x, ir: ai_x * br_x};
  end

  logic signed [P-1:0] rr, ii, ri, ir;
  assign rr = {s2.rr[PW-1], s2.rr};
  assign ii = {s2.ii[PW-1], s2.ii};
  assign ri = {s2.ri[PW-1], s2.ri};
  assign ir = {s2.ir[PW-1], s2.ir};

  // Conjugation only flips which partial product is subtracted; IN1 itself
  // is never negated, so the most-negative twiddle cannot overflow.
  logic [1:0][P-1:0] sum;
  always_comb begin
    sum = '0;
    if (s2.conj) begin
      sum[0] = rr + ii;
      sum[1] = ir - ri;
    end else begin
      sum[0] = rr - ii;
      sum[1] = ri + ir;
    end
  end

  logic [1:0][OUT_W-1:0] res;
`ifdef CMUL_SAT_EN
  logic [1:0] sat;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_scale
    cmul_scale #(.P(P), .OUT_W(OUT_W), .SH(SH), .ROUND(ROUND)) u_scale (
      .sum (sum[g]),
      .res (res[g])
`ifdef CMUL_SAT_EN
      , .sat (sat[g])
`endif
    );
  end

  // S3: register the scaled result as the output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      out_q <= '0;
    else if (!stall) out_q <= res;
  end

`ifdef CMUL_SAT_EN
  logic ovf_q;
  assign OVF = ovf_q;

  // Sticky: any clamp on a valid sample entering the output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                 ovf_q <= 1'b0;
    else if (vld_pipe[2] && !stall && (|sat))   ovf_q <= 1'b1;
  end
`else
  assign OVF = 1'b0;
`endif
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed bench for complex_mult_pipe. A second instance with ROUND=0
// shares the stimulus so truncation can be compared with rounding.
module tb_complex_mult_pipe;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic IN_VALID = 1'b0;
  logic CONJ = 1'b0;
  logic OUT_READY = 1'b1;
  logic signed [15:0] in0_re = '0, in0_im = '0;
  logic signed [11:0] in1_re = '0, in1_im = '0;
  logic IN_READY, OUT_VALID, OVF;
  logic signed [15:0] OUT_Real, OUT_Img;
  logic t_in_ready, t_out_valid, t_ovf;
  logic signed [15:0] t_re, t_im;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  complex_mult_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CONJ(CONJ), .IN0_Real(in0_re), .IN0_Img(in0_im),
    .IN1_Real(in1_re), .IN1_Img(in1_im), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_Real(OUT_Real), .OUT_Img(OUT_Img), .OVF(OVF)
  );

  complex_mult_pipe #(.ROUND(0)) dut_t (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(t_in_ready),
    .CONJ(CONJ), .IN0_Real(in0_re), .IN0_Img(in0_im),
    .IN1_Real(in1_re), .IN1_Img(in1_im), .OUT_VALID(t_out_valid),
    .OUT_READY(OUT_READY), .OUT_Real(t_re), .OUT_Img(t_im), .OVF(t_ovf)
  );

  // Output collector: one entry per completed output handshake.
  logic collect = 1'b0;
  int   cyc = 0;
  int   q_re[$], q_im[$], q_cyc[$];
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (collect && OUT_VALID && OUT_READY) begin
      q_re.push_back(int'(OUT_Real));
      q_im.push_back(int'(OUT_Img));
      q_cyc.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_in(input int a_re, input int a_im, input int b_re,
                        input int b_im, input logic cj);
    in0_re = 16'(a_re); in0_im = 16'(a_im);
    in1_re = 12'(b_re); in1_im = 12'(b_im);
    CONJ = cj;
  endtask

  // Push one sample and wait for it; lat counts edges from presentation
  // (accepting edge is 1), capped at 10 on timeout.
  task automatic run_one(input int a_re, input int a_im, input int b_re,
                         input int b_im, input logic cj,
                         output int re, output int im, output int tre,
                         output int lat);
    set_in(a_re, a_im, b_re, b_im, cj);
    IN_VALID = 1'b1;
    tick();
    lat = 1;
    IN_VALID = 1'b0;
    while (!OUT_VALID && lat < 10) begin
      tick();
      lat++;
    end
    re  = int'(OUT_Real);
    im  = int'(OUT_Img);
    tre = int'(t_re);
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    tests++; if (OUT_Real !== 16'sd0) begin fails++; $display("FAIL reset_out_real: got %0d want 0", OUT_Real); end
    tests++; if (OUT_Img !== 16'sd0) begin fails++; $display("FAIL reset_out_img: got %0d want 0", OUT_Img); end
    tests++; if (OVF !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    RST_N = 1'b1;
    #1;
    tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    tests++; if (t_in_ready !== 1'b1 || t_ovf !== 1'b0) begin fails++; $display("FAIL reset_trunc_inst: in_ready %b ovf %b want 1 0", t_in_ready, t_ovf); end
    tick();
  endtask

  task automatic test_basic();
    int re, im, tre, lat;
    // 1.0 * (0.5+0.5j)
    run_one(256, 0, 512, 512, 1'b0, re, im, tre, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", lat); end
    tests++; if (re != 128 || im != 128) begin fails++; $display("FAIL basic_mul: got (%0d,%0d) want (128,128)", re, im); end
    run_one(256, 0, 512, 512, 1'b1, re, im, tre, lat);
    tests++; if (re != 128 || im != -128) begin fails++; $display("FAIL basic_conj: got (%0d,%0d) want (128,-128)", re, im); end
    // (1+2j)*(0.5+1j) = -1.5+2j ; (1+2j)*(0.5-1j) = 2.5
    run_one(256, 512, 512, 1024, 1'b0, re, im, tre, lat);
    tests++; if (re != -384 || im != 512) begin fails++; $display("FAIL basic_cross: got (%0d,%0d) want (-384,512)", re, im); end
    run_one(256, 512, 512, 1024, 1'b1, re, im, tre, lat);
    tests++; if (re != 640 || im != 0) begin fails++; $display("FAIL basic_cross_conj: got (%0d,%0d) want (640,0)", re, im); end
  endtask

  task automatic test_back_to_back();
    q_re.delete(); q_im.delete(); q_cyc.delete();
    collect = 1'b1;
    // sample k: (k*1.0) * (0.5+0.5j), conjugated on even k
    for (int k = 1; k <= 8; k++) begin
      set_in(k * 256, 0, 512, 512, (k % 2 == 0));
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    repeat (5) tick();
    collect = 1'b0;
    tests++;
    if (q_re.size() != 8) begin
      fails++; $display("FAIL b2b_count: got %0d want 8", q_re.size());
    end else begin
      for (int k = 1; k <= 8; k++) begin
        tests++;
        if (q_re[k-1] != 128 * k || q_im[k-1] != ((k % 2 == 0) ? -128 * k : 128 * k)) begin
          fails++; $display("FAIL b2b_sample%0d: got (%0d,%0d) want (%0d,%0d)", k, q_re[k-1], q_im[k-1],
                            128 * k, (k % 2 == 0) ? -128 * k : 128 * k);
        end
      end
      tests++;
      if (q_cyc[7] - q_cyc[0] != 7) begin fails++; $display("FAIL b2b_gapless: span %0d want 7", q_cyc[7] - q_cyc[0]); end
    end
  endtask

  task automatic test_rounding();
    int re, im, tre, lat;
    run_one(1, 0, 512, 0, 1'b0, re, im, tre, lat);
    tests++; if (re != 1) begin fails++; $display("FAIL round_half_up: got %0d want 1", re); end
    tests++; if (tre != 0) begin fails++; $display("FAIL trunc_pos: got %0d want 0", tre); end
    run_one(-1, 0, 512, 0, 1'b0, re, im, tre, lat);
    tests++; if (re != 0) begin fails++; $display("FAIL round_neg_half: got %0d want 0", re); end
    tests++; if (tre != -1) begin fails++; $display("FAIL trunc_neg: got %0d want -1", tre); end
  endtask

  task automatic test_overflow();
    int re, im, tre, lat;
    int exp_im;
    logic exp_ovf;
`ifdef CMUL_SAT_EN
    exp_im = 32767; exp_ovf = 1'b1;
`else
    exp_im = -66;   exp_ovf = 1'b0;
`endif
    run_one(32767, 32767, 1023, 1023, 1'b0, re, im, tre, lat);
    tests++; if (re != 0 || im != exp_im) begin fails++; $display("FAIL ovf_value: got (%0d,%0d) want (0,%0d)", re, im, exp_im); end
    tests++; if (OVF !== exp_ovf) begin fails++; $display("FAIL ovf_flag: got %b want %b", OVF, exp_ovf); end
    run_one(256, 0, 512, 512, 1'b0, re, im, tre, lat);
    tests++; if (re != 128 || im != 128) begin fails++; $display("FAIL ovf_after_normal: got (%0d,%0d) want (128,128)", re, im); end
    tests++; if (OVF !== exp_ovf) begin fails++; $display("FAIL ovf_sticky: got %b want %b", OVF, exp_ovf); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int stall_left = -1;
    int snap_re = 0, snap_im = 0;
    logic acc;
    q_re.delete(); q_im.delete(); q_cyc.delete();
    collect = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (idx < 6) begin set_in((idx + 1) * 256, 0, 512, 512, 1'b0); IN_VALID = 1'b1; end
      else IN_VALID = 1'b0;
      if (stall_left < 0 && OUT_VALID) stall_left = 5;
      OUT_READY = !(stall_left > 0);
      @(negedge CLK);
      if (stall_left > 0) begin
        if (stall_left == 5) begin
          snap_re = int'(OUT_Real); snap_im = int'(OUT_Img);
        end else begin
          tests++;
          if (int'(OUT_Real) != snap_re || int'(OUT_Img) != snap_im || OUT_VALID !== 1'b1) begin
            fails++; $display("FAIL bp_hold: got (%0d,%0d) v=%b want (%0d,%0d) v=1", OUT_Real, OUT_Img, OUT_VALID, snap_re, snap_im);
          end
        end
        tests++;
        if (IN_READY !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", IN_READY); end
        stall_left--;
      end
      acc = IN_VALID && IN_READY;
      @(posedge CLK); #1;
      if (acc) idx++;
      if (idx == 6 && stall_left == 0 && q_re.size() == 6) break;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    collect = 1'b0;
    tests++; if (stall_left != 0) begin fails++; $display("FAIL bp_stall_seen: stall_left %0d want 0", stall_left); end
    tests++; if (idx != 6) begin fails++; $display("FAIL bp_accepted: got %0d want 6", idx); end
    tests++;
    if (q_re.size() != 6) begin
      fails++; $display("FAIL bp_count: got %0d want 6", q_re.size());
    end else begin
      for (int k = 1; k <= 6; k++) begin
        tests++;
        if (q_re[k-1] != 128 * k || q_im[k-1] != 128 * k) begin
          fails++; $display("FAIL bp_order%0d: got (%0d,%0d) want (%0d,%0d)", k, q_re[k-1], q_im[k-1], 128 * k, 128 * k);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int re, im, tre, lat;
    OUT_READY = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_in(k * 256, 0, 512, 512, 1'b0);
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    tests++; if (OUT_VALID !== 1'b1 || OUT_Real !== 16'sd128) begin fails++; $display("FAIL rstmid_pre: v=%b re=%0d want v=1 re=128", OUT_VALID, OUT_Real); end
    #2 RST_N = 1'b0;
    #1;
    tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", OUT_VALID); end
    tests++; if (OUT_Real !== 16'sd0 || OUT_Img !== 16'sd0) begin fails++; $display("FAIL rstmid_data: got (%0d,%0d) want (0,0)", OUT_Real, OUT_Img); end
    tests++; if (OVF !== 1'b0) begin fails++; $display("FAIL rstmid_ovf: got %b want 0", OVF); end
    tick();
    #2 RST_N = 1'b1;
    tick();
    tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL rstmid_flushed: got %b want 0", OUT_VALID); end
    run_one(256, 0, 512, 512, 1'b1, re, im, tre, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL rstmid_latency: got %0d want 3", lat); end
    tests++; if (re != 128 || im != -128) begin fails++; $display("FAIL rstmid_value: got (%0d,%0d) want (128,-128)", re, im); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
